// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue/result stage:
// RV32M multiply funct3 codes and the controller state encoding.
package mul_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_RESP = 2'd3
    } state_e;

endpackage

// File: rtl/mul_sign_fix.sv
// Product sign correction and result-half selection.
// Pure combinational; the caller registers the result.
module mul_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] prod,
    input  logic              neg,
    input  logic              is_low,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] p;

    assign p      = neg ? -prod : prod;
    assign result = is_low ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];

endmodule

// File: rtl/multiplier_issue_ctrl.sv
// Issue/result stage around the multi-cycle unsigned multiplier:
// magnitude conversion, run watchdog, sign fix and result handshake.
module multiplier_issue_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    output logic              mult_en_o,
    output logic              mult_clr_o,
    output logic [XLEN-1:0]   op_a_o,
    output logic [XLEN-1:0]   op_b_o,
    input  logic              done_i,
    input  logic [2*XLEN-1:0] product_i,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic              err_o
);

    state_e state_q, state_d;

    logic [2:0]        f3_q;
    logic              neg_q;
    logic [CNT_W-1:0]  wdog_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN-1:0]   fix_res;

    logic sa, sb;
    logic illegal, zero_op, timeout;

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (1'b1)
            funct3_i == F3_MULH: begin
                sa = rs1_i[XLEN-1];
                sb = rs2_i[XLEN-1];
            end
            funct3_i == F3_MULHSU: sa = rs1_i[XLEN-1];
            default: ;
        endcase
    end

    assign illegal = funct3_i[2];
    assign zero_op = (rs1_i == '0) || (rs2_i == '0);
    // Last permitted RUN cycle: the count would reach TIMEOUT_CYC here.
    assign timeout = (wdog_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    if (illegal || zero_op) state_d = S_RESP;
                    else                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (done_i)       state_d = S_FIX;
                else if (timeout) state_d = S_RESP;
            end
            S_FIX:  state_d = S_RESP;
            S_RESP: if (result_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_o        = (state_q == S_IDLE);
        mult_en_o      = (state_q == S_RUN);
        result_valid_o = (state_q == S_RESP);
        // The multiplier's DONE is sticky, so clear it after every run.
        mult_clr_o     = (state_q == S_FIX) ||
                         ((state_q == S_RUN) && timeout && !done_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f3_q     <= '0;
            neg_q    <= 1'b0;
            op_a_o   <= '0;
            op_b_o   <= '0;
            wdog_q   <= '0;
            prod_q   <= '0;
            result_o <= '0;
            err_o    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        f3_q     <= funct3_i;
                        neg_q    <= sa ^ sb;
                        op_a_o   <= sa ? -rs1_i : rs1_i;
                        op_b_o   <= sb ? -rs2_i : rs2_i;
                        wdog_q   <= '0;
                        result_o <= '0;
                        err_o    <= illegal;
                    end
                end
                S_RUN: begin
                    wdog_q <= wdog_q + CNT_W'(1);
                    if (done_i) begin
                        prod_q <= product_i;
                    end else if (timeout) begin
                        err_o    <= 1'b1;
                        result_o <= '0;
                    end
                end
                S_FIX: result_o <= fix_res;
                S_RESP: begin
                    if (result_ready_i) begin
                        err_o  <= 1'b0;
                        wdog_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    mul_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .prod   (prod_q),
        .neg    (neg_q),
        .is_low (f3_q == F3_MUL),
        .result (fix_res)
    );

endmodule

// File: tb/tb_multiplier_issue_ctrl.sv
// Directed bench for multiplier_issue_ctrl with a behavioural
// multiplier and a scoreboard of expected {err, result} pairs.
module tb_multiplier_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        mult_en_o, mult_clr_o;
    logic [31:0] op_a_o, op_b_o;
    logic        done_i;
    logic [63:0] product_i;
    logic        result_valid_o;
    logic        result_ready_i;
    logic [31:0] result_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;
    int en_cnt, clr_cnt;
    int mcnt;
    logic never_done;
    logic [32:0] sb_q[$];

    always #5 clk_i = ~clk_i;

    multiplier_issue_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .funct3_i       (funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .mult_en_o      (mult_en_o),
        .mult_clr_o     (mult_clr_o),
        .op_a_o         (op_a_o),
        .op_b_o         (op_b_o),
        .done_i         (done_i),
        .product_i      (product_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_o       (result_o),
        .err_o          (err_o)
    );

    // Multiplier model: done during its 7th enabled cycle, sticky until clear.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)         mcnt <= 0;
        else if (mult_clr_o) mcnt <= 0;
        else if (mult_en_o)  mcnt <= mcnt + 1;
    end
    assign done_i    = !never_done && (mcnt >= 6);
    assign product_i = {32'b0, op_a_o} * {32'b0, op_b_o};

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (mult_en_o)  en_cnt++;
            if (mult_clr_o) clr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference {err, result} from signed 66-bit arithmetic.
    function automatic logic [32:0] ref_op(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [65:0] x, y, p;
        if (f3[2]) return {1'b1, 32'h0};
        if (a == 0 || b == 0) return 33'h0;
        x = (f3 == 3'b001 || f3 == 3'b010) ? {{34{a[31]}}, a} : {34'b0, a};
        y = (f3 == 3'b001) ? {{34{b[31]}}, b} : {34'b0, b};
        p = x * y;
        return (f3 == 3'b000) ? {1'b0, p[31:0]} : {1'b0, p[63:32]};
    endfunction

    task automatic run_op(input string name, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit to, input int exp_lat,
                          input int exp_en, input int exp_clr,
                          input int stall);
        int lat;
        logic [32:0] e;
        logic [31:0] r0;
        logic e0;
        chk({name, "_ready_idle"}, 64'(ready_o), 64'd1);
        sb_q.push_back(to ? {1'b1, 32'h0} : ref_op(f3, a, b));
        en_cnt   = 0;
        clr_cnt  = 0;
        valid_i  = 1'b1;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!result_valid_o && lat < 64) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        e = sb_q.pop_front();
        chk({name, "_result"}, 64'({err_o, result_o}), 64'(e));
        r0 = result_o;
        e0 = err_o;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk_i); #1;
            chk({name, "_stall_res"}, 64'({e0, r0}), 64'({err_o, result_o}));
            chk({name, "_stall_rv"}, 64'({result_valid_o, ready_o}), 64'b10);
        end
        result_ready_i = 1'b1;
        @(posedge clk_i); #1;
        result_ready_i = 1'b0;
        chk({name, "_post_hs"}, 64'({ready_o, result_valid_o, err_o}), 64'b100);
        chk({name, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
        chk({name, "_clr_pulses"}, 64'(clr_cnt), 64'(exp_clr));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"},
            64'({ready_o, mult_en_o, mult_clr_o, result_valid_o, err_o}),
            64'b10000);
        chk({tag, "_data"}, {result_o, op_a_o}, 64'h0);
        chk({tag, "_opb"}, 64'(op_b_o), 64'h0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        valid_i        = 1'b0;
        funct3_i       = 3'b000;
        rs1_i          = '0;
        rs2_i          = '0;
        result_ready_i = 1'b0;
        never_done     = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_outs("reset");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 9, 7, 1, 0);
        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 0, 9, 7, 1, 0);
        chk("mulh_min_ops", {op_a_o, op_b_o}, 64'h8000_0000_8000_0000);
        run_op("mulh_m3x5", 3'b001, 32'hFFFF_FFFD, 32'd5, 0, 9, 7, 1, 0);
        chk("mulh_m3x5_ops", {op_a_o, op_b_o}, 64'h0000_0003_0000_0005);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 9, 7, 1, 0);
        chk("mulhsu_ops", {op_a_o, op_b_o}, 64'h0000_0001_FFFF_FFFF);
        run_op("mul_m3x5", 3'b000, 32'hFFFF_FFFD, 32'd5, 0, 9, 7, 1, 5);
        chk("mul_ops", {op_a_o, op_b_o}, 64'hFFFF_FFFD_0000_0005);
        run_op("mul_zero", 3'b000, 32'h0, 32'h1234, 0, 1, 0, 0, 0);
        run_op("illegal", 3'b100, 32'h7, 32'h9, 0, 1, 0, 0, 2);

        never_done = 1'b1;
        run_op("timeout", 3'b011, 32'd5, 32'd7, 1, 17, 16, 1, 0);
        never_done = 1'b0;
        run_op("after_to", 3'b000, 32'h1234_5678, 32'h9ABC_DEF1, 0, 9, 7, 1, 0);

        valid_i  = 1'b1;
        funct3_i = 3'b000;
        rs1_i    = 32'd7;
        rs2_i    = 32'd9;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mid_run", 64'(mult_en_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        chk_reset_outs("rst_async");
        @(posedge clk_i); #1;
        chk_reset_outs("rst_next");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_release", 64'({ready_o, result_valid_o}), 64'b10);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
